// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer: store-queue packet, memory size and buffer entry.
// Pure type/constant package; no logic, no latency, no flow control.
package store_write_buffer_pkg;

    localparam int NUM_SQ_DCACHE         = 2;
    localparam int NUM_FU_LOAD           = 2;
    localparam int WB_LEN_DEFAULT        = 4;
    localparam int FLUSH_TIMEOUT_DEFAULT = 8;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'h0,
        MEM_HALF   = 2'h1,
        MEM_WORD   = 2'h2,
        MEM_DOUBLE = 2'h3
    } mem_size_t;

    typedef struct packed {
        logic      sign;
        mem_size_t size;
    } mem_func_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        mem_func_t   sign_size;
        logic [31:0] data;
    } sq_dcache_packet_t;

    typedef struct packed {
        logic        valid;
        logic        locked;
        logic [28:0] blk;
        logic [63:0] data;
        logic [7:0]  mask;
    } wb_entry_t;

endpackage

// File: rtl/store_write_buffer_byte_place.sv
// Places an unaligned store (data in low bits) into its 8-byte block lane with a byte mask.
// Purely combinational, zero latency, no flow control.
module wb_byte_place
    import store_write_buffer_pkg::*;
(
    input  logic [2:0]  offset,
    input  mem_size_t   size,
    input  logic [31:0] data,
    output logic [63:0] data64,
    output logic [7:0]  mask8
);

    logic [2:0]  base;
    logic [7:0]  raw_mask;
    logic [63:0] raw_data;

    always_comb begin
        base     = offset;
        raw_mask = 8'h01;
        raw_data = {56'b0, data[7:0]};
        case (size)
            MEM_BYTE: begin
                base     = offset;
                raw_mask = 8'h01;
                raw_data = {56'b0, data[7:0]};
            end
            MEM_HALF: begin
                base     = {offset[2:1], 1'b0};
                raw_mask = 8'h03;
                raw_data = {48'b0, data[15:0]};
            end
            default: begin
                base     = {offset[2], 2'b00};
                raw_mask = 8'h0F;
                raw_data = {32'b0, data};
            end
        endcase
        mask8  = raw_mask << base;
        data64 = raw_data << {base, 3'b000};
    end

endmodule

// File: rtl/store_write_buffer.sv
// Coalescing store write buffer: merges SQ stores into 8-byte entries, drains FIFO-order to dcache, forwards to loads.
// Entry visible one cycle after accept; sq_accept is a contiguous lane prefix stalled only by a full buffer.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int N_IN          = NUM_SQ_DCACHE,
    parameter int WB_LEN        = WB_LEN_DEFAULT,
    parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEFAULT,
    parameter int N_LD          = NUM_FU_LOAD
)(
    input  logic              clock,
    input  logic              reset,
    input  sq_dcache_packet_t sq_packet [N_IN],
    output logic [N_IN-1:0]   sq_accept,
    input  logic              flush,
    output logic              wb_valid,
    output logic [28:0]       wb_addr,
    output logic [63:0]       wb_data,
    output logic [7:0]        wb_mask,
    input  logic              wb_accept,
    input  logic [31:0]       ld_addr [N_LD],
    output logic [31:0]       ld_fwd_data [N_LD],
    output logic [3:0]        ld_fwd_mask [N_LD],
    output logic              empty
);

    localparam int IDX_W  = (WB_LEN > 1) ? $clog2(WB_LEN) : 1;
    localparam int CNT_W  = $clog2(WB_LEN + 1);
    localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    typedef logic [IDX_W-1:0] wb_idx_t;

    function automatic wb_idx_t idx_inc(input wb_idx_t i);
        return (int'(i) == WB_LEN - 1) ? '0 : i + wb_idx_t'(1);
    endfunction

    function automatic wb_idx_t idx_dec(input wb_idx_t i);
        return (i == '0) ? wb_idx_t'(WB_LEN - 1) : i - wb_idx_t'(1);
    endfunction

    wb_entry_t         ent     [WB_LEN];
    wb_entry_t         ent_nxt [WB_LEN];
    wb_idx_t           head, tail, head_nxt, tail_nxt, tail_w, young;
    logic [CNT_W-1:0]  count, count_nxt, cnt_w;
    logic [1:0]        state, state_nxt;
    logic [IDLE_W-1:0] idle, idle_nxt;
    logic              empty_q;
    logic              stop, merge, any_acc, drain_now, drain_cond;

    logic [63:0] place_data [N_IN];
    logic [7:0]  place_mask [N_IN];

    for (genvar g = 0; g < N_IN; g++) begin : g_place
        wb_byte_place u_place (
            .offset (sq_packet[g].addr[2:0]),
            .size   (sq_packet[g].sign_size.size),
            .data   (sq_packet[g].data),
            .data64 (place_data[g]),
            .mask8  (place_mask[g])
        );
    end

    // Lane acceptance never looks at wb_accept: a slot freed this cycle is reusable only next cycle.
    always_comb begin
        ent_nxt   = ent;
        sq_accept = '0;
        tail_w    = tail;
        cnt_w     = count;
        stop      = reset;
        young     = '0;
        merge     = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            young = idx_dec(tail_w);
            merge = (cnt_w != '0) && ent_nxt[young].valid && !ent_nxt[young].locked &&
                    (ent_nxt[young].blk == sq_packet[i].addr[31:3]);
            if (stop || !sq_packet[i].valid) begin
                stop = 1'b1;
            end else if (merge) begin
                for (int b = 0; b < 8; b++) begin
                    if (place_mask[i][b]) begin
                        ent_nxt[young].data[8*b +: 8] = place_data[i][8*b +: 8];
                    end
                end
                ent_nxt[young].mask = ent_nxt[young].mask | place_mask[i];
                sq_accept[i] = 1'b1;
            end else if (int'(cnt_w) < WB_LEN) begin
                ent_nxt[tail_w].valid  = 1'b1;
                ent_nxt[tail_w].locked = 1'b0;
                ent_nxt[tail_w].blk    = sq_packet[i].addr[31:3];
                ent_nxt[tail_w].data   = place_data[i];
                ent_nxt[tail_w].mask   = place_mask[i];
                tail_w       = idx_inc(tail_w);
                cnt_w        = cnt_w + CNT_W'(1);
                sq_accept[i] = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end

        any_acc   = |sq_accept;
        drain_now = (state == ST_DRAIN) && wb_accept;
        head_nxt  = head;
        tail_nxt  = tail_w;
        count_nxt = cnt_w;
        if (drain_now) begin
            ent_nxt[head] = '0;
            head_nxt      = idx_inc(head);
            count_nxt     = cnt_w - CNT_W'(1);
        end

        if (any_acc) begin
            idle_nxt = '0;
        end else if (state == ST_COLLECT && idle != IDLE_W'(FLUSH_TIMEOUT)) begin
            idle_nxt = idle + IDLE_W'(1);
        end else if (state == ST_EMPTY) begin
            idle_nxt = '0;
        end else begin
            idle_nxt = idle;
        end

        // Judged on post-edge values so a pair of stores or a timeout raises wb_valid on the next cycle.
        drain_cond = (count_nxt >= CNT_W'(2)) || (idle_nxt == IDLE_W'(FLUSH_TIMEOUT)) || flush;

        state_nxt = state;
        case (state)
            ST_EMPTY:   if (any_acc) state_nxt = drain_cond ? ST_DRAIN : ST_COLLECT;
            ST_COLLECT: if (drain_cond) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_now) begin
                    if (count_nxt == '0)  state_nxt = ST_EMPTY;
                    else if (drain_cond)  state_nxt = ST_DRAIN;
                    else                  state_nxt = ST_COLLECT;
                end
            end
            default:    state_nxt = ST_EMPTY;
        endcase

        if (state_nxt == ST_DRAIN) begin
            ent_nxt[head_nxt].locked = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WB_LEN; i++) begin
                ent[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            state   <= ST_EMPTY;
            idle    <= '0;
            empty_q <= 1'b1;
        end else begin
            ent     <= ent_nxt;
            head    <= head_nxt;
            tail    <= tail_nxt;
            count   <= count_nxt;
            state   <= state_nxt;
            idle    <= idle_nxt;
            empty_q <= (count_nxt == '0);
        end
    end

    assign wb_valid = (state == ST_DRAIN);
    assign wb_addr  = wb_valid ? ent[head].blk  : '0;
    assign wb_data  = wb_valid ? ent[head].data : '0;
    assign wb_mask  = wb_valid ? ent[head].mask : '0;
    assign empty    = empty_q;

    int          fwd_k;
    logic [3:0]  fwd_wmask;
    logic [31:0] fwd_wdata;

    always_comb begin
        fwd_k     = 0;
        fwd_wmask = '0;
        fwd_wdata = '0;
        for (int l = 0; l < N_LD; l++) begin
            ld_fwd_data[l] = '0;
            ld_fwd_mask[l] = '0;
            for (int i = 0; i < WB_LEN; i++) begin
                fwd_k = int'(head) + i;
                if (fwd_k >= WB_LEN) fwd_k = fwd_k - WB_LEN;
                fwd_wmask = ld_addr[l][2] ? ent[fwd_k].mask[7:4] : ent[fwd_k].mask[3:0];
                fwd_wdata = ld_addr[l][2] ? ent[fwd_k].data[63:32] : ent[fwd_k].data[31:0];
                if (ent[fwd_k].valid && ent[fwd_k].blk == ld_addr[l][31:3]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (fwd_wmask[b]) ld_fwd_data[l][8*b +: 8] = fwd_wdata[8*b +: 8];
                    end
                    ld_fwd_mask[l] = ld_fwd_mask[l] | fwd_wmask;
                end
            end
        end
    end

    logic unused_bits;
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < N_IN; i++) unused_bits = unused_bits ^ sq_packet[i].sign_size.sign;
        for (int l = 0; l < N_LD; l++) unused_bits = unused_bits ^ (^ld_addr[l][1:0]);
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: timeout drain, merging, full backpressure, locking, forwarding, reset.
module tb_store_write_buffer;
    import store_write_buffer_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    sq_dcache_packet_t sq_packet [2];
    logic [1:0]        sq_accept;
    logic              flush;
    logic              wb_valid;
    logic [28:0]       wb_addr;
    logic [63:0]       wb_data;
    logic [7:0]        wb_mask;
    logic              wb_accept;
    logic [31:0]       ld_addr [2];
    logic [31:0]       ld_fwd_data [2];
    logic [3:0]        ld_fwd_mask [2];
    logic              empty;

    int n_assert = 0;
    int n_fail   = 0;
    int waited;

    store_write_buffer #(.N_IN(2), .WB_LEN(4), .FLUSH_TIMEOUT(8), .N_LD(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .sq_packet   (sq_packet),
        .sq_accept   (sq_accept),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_mask     (wb_mask),
        .wb_accept   (wb_accept),
        .ld_addr     (ld_addr),
        .ld_fwd_data (ld_fwd_data),
        .ld_fwd_mask (ld_fwd_mask),
        .empty       (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) sq_packet[i] = '0;
        flush     = 1'b0;
        wb_accept = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] addr, input mem_size_t sz, input logic [31:0] d);
        sq_packet[i].valid          = 1'b1;
        sq_packet[i].addr           = addr;
        sq_packet[i].sign_size.sign = 1'b0;
        sq_packet[i].sign_size.size = sz;
        sq_packet[i].data           = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        ld_addr[0] = 32'h1000;
        ld_addr[1] = 32'h0;

        // reset state
        @(negedge clock);
        set_lane(0, 32'h1000, MEM_WORD, 32'h1);
        #1 check("rst_sq_accept", sq_accept, 0);
        @(negedge clock);
        clear_inputs();
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_wb_mask", wb_mask, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fwd_mask", ld_fwd_mask[0], 0);
        reset = 1'b0;

        // single store drains after the idle timeout
        set_lane(0, 32'h1000, MEM_WORD, 32'hDEADBEEF);
        #1 check("t1_accept", sq_accept, 2'b01);
        @(negedge clock);
        clear_inputs();
        #1;
        check("t1_fwd_mask", ld_fwd_mask[0], 4'hF);
        check("t1_fwd_data", ld_fwd_data[0], 32'hDEADBEEF);
        check("t1_not_empty", empty, 0);
        waited = 0;
        while (!wb_valid && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        #1;
        check("t1_timeout_cycles", waited, 8);
        check("t1_wb_addr", wb_addr, 29'h200);
        check("t1_wb_mask", wb_mask, 8'h0F);
        check("t1_wb_data", wb_data, 64'h0000_0000_DEAD_BEEF);
        wb_accept = 1'b1;
        @(negedge clock);
        wb_accept = 1'b0;
        #1;
        check("t1_drained_valid", wb_valid, 0);
        check("t1_drained_empty", empty, 1);

        // same-cycle merge of SB and SH into one block
        set_lane(0, 32'h1004, MEM_BYTE, 32'h11);
        set_lane(1, 32'h1006, MEM_HALF, 32'h2233);
        #1 check("t2_accept", sq_accept, 2'b11);
        @(negedge clock);
        clear_inputs();
        ld_addr[0] = 32'h1004;
        #1;
        check("t2_fwd_mask", ld_fwd_mask[0], 4'hD);
        check("t2_fwd_data", ld_fwd_data[0] & 32'hFFFF_00FF, 32'h2233_0011);
        check("t2_collect_valid", wb_valid, 0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        check("t2_wb_valid", wb_valid, 1);
        check("t2_wb_addr", wb_addr, 29'h200);
        check("t2_wb_mask", wb_mask, 8'hD0);
        check("t2_wb_data_hi", wb_data[63:32] & 32'hFFFF_00FF, 32'h2233_0011);
        wb_accept = 1'b1;
        @(negedge clock);
        wb_accept = 1'b0;
        #1 check("t2_empty", empty, 1);

        // fill four blocks with the dcache stalled
        set_lane(0, 32'h3000, MEM_WORD, 32'h1);
        set_lane(1, 32'h3008, MEM_WORD, 32'h2);
        #1 check("t3_accept_a", sq_accept, 2'b11);
        @(negedge clock);
        clear_inputs();
        #1;
        check("t3_pair_wb_valid", wb_valid, 1);
        check("t3_pair_wb_addr", wb_addr, 29'h600);
        set_lane(0, 32'h3010, MEM_WORD, 32'h3);
        set_lane(1, 32'h3018, MEM_WORD, 32'h4);
        #1 check("t3_accept_b", sq_accept, 2'b11);
        @(negedge clock);
        clear_inputs();
        set_lane(0, 32'h3020, MEM_WORD, 32'h5);
        set_lane(1, 32'h3028, MEM_WORD, 32'h6);
        #1 check("t3_full_reject", sq_accept, 2'b00);
        wb_accept = 1'b1;
        #1 check("t3_full_reject_wbacc", sq_accept, 2'b00);
        wb_accept = 1'b0;
        set_lane(0, 32'h3019, MEM_BYTE, 32'hAA);
        set_lane(1, 32'h3020, MEM_WORD, 32'h5);
        #1 check("t3_full_merge", sq_accept, 2'b01);
        @(negedge clock);
        clear_inputs();
        ld_addr[0] = 32'h3018;
        #1;
        check("t3_fwd_mask", ld_fwd_mask[0], 4'hF);
        check("t3_fwd_data", ld_fwd_data[0], 32'h0000_AA04);
        check("t3_head_stable_addr", wb_addr, 29'h600);
        check("t3_head_stable_data", wb_data, 64'h1);
        wb_accept = 1'b1;
        flush     = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("t3_order_valid", wb_valid, 1);
            check("t3_order_addr", wb_addr, 64'h600 + 64'(j));
            @(negedge clock);
        end
        clear_inputs();
        #1;
        check("t3_done_valid", wb_valid, 0);
        check("t3_done_empty", empty, 1);

        // locked head never merges; new entry drains after it
        set_lane(0, 32'h1000, MEM_BYTE, 32'h77);
        flush = 1'b1;
        #1 check("t4_accept_a", sq_accept, 2'b01);
        @(negedge clock);
        clear_inputs();
        #1 check("t4_head_mask", wb_mask, 8'h01);
        set_lane(0, 32'h1001, MEM_BYTE, 32'h55);
        #1 check("t4_accept_b", sq_accept, 2'b01);
        @(negedge clock);
        clear_inputs();
        ld_addr[0] = 32'h1000;
        #1;
        check("t4_head_mask_kept", wb_mask, 8'h01);
        check("t4_head_data_kept", wb_data, 64'h77);
        check("t4_fwd_mask", ld_fwd_mask[0], 4'h3);
        check("t4_fwd_data", ld_fwd_data[0], 32'h0000_5577);
        wb_accept = 1'b1;
        flush     = 1'b1;
        #1 check("t4_first_mask", wb_mask, 8'h01);
        @(negedge clock);
        #1;
        check("t4_second_valid", wb_valid, 1);
        check("t4_second_addr", wb_addr, 29'h200);
        check("t4_second_mask", wb_mask, 8'h02);
        check("t4_second_data", wb_data, 64'h5500);
        @(negedge clock);
        clear_inputs();
        #1 check("t4_empty", empty, 1);

        // forwarding: younger entry overrides older, same-cycle store invisible
        set_lane(0, 32'h2000, MEM_WORD, 32'hAABBCCDD);
        flush = 1'b1;
        @(negedge clock);
        clear_inputs();
        set_lane(0, 32'h2001, MEM_BYTE, 32'h55);
        @(negedge clock);
        clear_inputs();
        ld_addr[0] = 32'h2000;
        ld_addr[1] = 32'h2004;
        set_lane(0, 32'h2002, MEM_BYTE, 32'h99);
        #1;
        check("t5_accept", sq_accept, 2'b01);
        check("t5_fwd_mask", ld_fwd_mask[0], 4'hF);
        check("t5_fwd_data", ld_fwd_data[0], 32'hAABB_55DD);
        check("t5_fwd_other_word", ld_fwd_mask[1], 4'h0);
        @(negedge clock);
        clear_inputs();
        #1;
        check("t5_fwd_data_next", ld_fwd_data[0], 32'hAA99_55DD);
        check("t5_head_data", wb_data, 64'hAABB_CCDD);

        // reset while draining discards entries
        check("t6_pre_valid", wb_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_valid", wb_valid, 0);
        check("t6_empty", empty, 1);
        check("t6_fwd_mask", ld_fwd_mask[0], 0);
        set_lane(0, 32'h4000, MEM_WORD, 32'h1234_5678);
        #1 check("t6_accept", sq_accept, 2'b01);
        @(negedge clock);
        clear_inputs();
        ld_addr[0] = 32'h4000;
        #1;
        check("t6_head_slot", 64'(dut.head), 0);
        check("t6_tail_slot", 64'(dut.tail), 1);
        check("t6_fwd_data", ld_fwd_data[0], 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Coalescing write buffer between the store queue's dcache port and the dcache write port. Accepts up to `N_IN` committed stores per cycle from the store queue, merges them into 8-byte-aligned block entries with byte masks, and drains entries to the dcache in FIFO order over a valid/accept handshake. It also returns byte-level forwarding data for loads, so that stores that have left the store queue but not yet reached the dcache stay visible.

## Interface
Parameters:
- `N_IN`, default `` `NUM_SQ_DCACHE `` (2): store lanes per cycle.
- `WB_LEN`, default 4: block entries; must be ≥ 2.
- `FLUSH_TIMEOUT`, default 8: idle cycles before a lone entry drains.
- `N_LD`, default `` `NUM_FU_LOAD ``: forwarding lookup lanes.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `sq_packet` in `SQ_DCACHE_PACKET[N_IN]`: {valid, addr, sign_size, data}. Data is unaligned, in the low bits.
- `sq_accept` out `[N_IN]`: lane consumed this cycle. Always a contiguous prefix from lane 0.
- `flush` in 1: force draining; used for fences and halt.
- `wb_valid` out 1: head entry presented to the dcache.
- `wb_addr` out 29: block address, `addr[31:3]`.
- `wb_data` out 64: block data.
- `wb_mask` out 8: byte enables.
- `wb_accept` in 1: dcache took the head entry.
- `ld_addr` in `ADDR[N_LD]`: load lookup addresses.
- `ld_fwd_data` out `DATA[N_LD]`: word-aligned forwarded bytes.
- `ld_fwd_mask` out `[N_LD][3:0]`: valid bytes of `ld_fwd_data`.
- `empty` out 1: no valid entries.

## Operation
- **Entry format:** {valid, locked, blk[28:0], data[63:0], mask[7:0]}. The buffer is a circular FIFO with head, tail and count. Head and tail wrap modulo `WB_LEN`.
- **Byte placement:**
  - BYTE: 1 byte at offset `addr[2:0]`.
  - HALF: 2 bytes at `{addr[2:1],0}`.
  - WORD: 4 bytes at `{addr[2],00}`.
  - Misaligned stores are not checked; behaviour is undefined.
- **Lane processing:** lanes are processed 0..N_IN-1. Lane i is accepted only if lane i-1 was accepted.
  1. If the youngest unlocked valid entry (including allocations made earlier this cycle) has `blk == addr[31:3]`, merge into it. Set the mask bits; newer bytes overwrite.
  2. Otherwise, allocate at the current tail if free slots remain after earlier lanes' allocations.
  3. Otherwise, stop accepting; lane i and all higher lanes get `sq_accept = 0`.
  - Merging only into the youngest entry preserves per-block program order.
- **Drain FSM:**
  - States: EMPTY, COLLECT, DRAIN.
  - EMPTY → COLLECT when any store is accepted.
  - COLLECT → DRAIN when any of the following holds: count ≥ 2, idle counter == `FLUSH_TIMEOUT`, or `flush`.
  - Entering DRAIN sets `locked` on the head entry. Locked entries never merge.
  - DRAIN: `wb_valid = 1`. On `wb_accept` the head is freed and head advances.
  - After a drain completes: go to DRAIN if the drain condition still holds, COLLECT if entries remain, otherwise EMPTY.
- **Idle counter:** counts cycles with no accepted store while in COLLECT. It resets on any accept and saturates at `FLUSH_TIMEOUT`.
- **Forwarding:** for each load lane, scan oldest to youngest over valid entries with a matching block. For bytes in word `ld_addr[2]`, younger entries override older ones. Output is the per-byte OR of the mask with the last writer's data. Fully combinational, reading registered entries only; stores accepted in the current cycle are not visible.
- **Simultaneous drain and accept:** a drain and an accept in the same cycle are allowed. The freed slot is not reusable until the next cycle. A full buffer with `wb_accept` still rejects new allocations that cycle, but merges into unlocked entries are accepted.

## Timing
- **Reset values:**
  - All entries cleared; head = tail = count = 0; state EMPTY; idle counter 0.
  - `sq_accept = 0`, `wb_valid = 0`, `wb_mask = 0`, `wb_addr = 0`, `wb_data = 0`, `empty = 1`, `ld_fwd_mask = 0`.
- **Reset mid-operation:** entries that were not drained are discarded. The store queue is reset in the same cycle.
- **Path types:**
  - `sq_accept` is combinational from `sq_packet` and registered state. It must not depend on `wb_accept`.
  - `wb_*` outputs are driven from registered state only.
- **Latencies:**
  - A store accepted in cycle t appears in an entry in t+1.
  - With count ≥ 2, `wb_valid` is asserted in t+1.
  - A lone store drains at the earliest in t+1+`FLUSH_TIMEOUT`.
- **Handshake:** `wb_valid` must hold with stable `wb_addr`, `wb_data` and `wb_mask` until `wb_accept` is sampled high. The entry is freed at that clock edge.
- **`empty`:** equals `(count == 0)`, registered.

## Structure
- Add to `sys_defs.svh`: `WB_ENTRY` struct, `WB_IDX` typedef (`$clog2(WB_LEN)`), and the `WB_LEN` and `FLUSH_TIMEOUT` macros. Reuse the existing `SQ_DCACHE_PACKET` and `MEM_FUNC`.
- Sub-module `wb_byte_place`: combinational. Takes {addr[2:0], size, data} and produces {data64, mask8}. Shared by the merge path.
- Forwarding and the FSM stay inline.

## Test plan
- **Single-store timeout:** one SW to 0x1000 with data 0xDEADBEEF, then idle.
  - `wb_valid` asserts exactly `FLUSH_TIMEOUT` cycles after the entry appears.
  - `wb_addr = 0x200`, `wb_mask = 0x0F`, `wb_data[31:0] = 0xDEADBEEF`.
- **Same-cycle merge:** SB 0x11→0x1004 on lane 0 and SH 0x2233→0x1006 on lane 1 in the same cycle.
  - Both accepted; one entry with `mask = 0xD0`.
  - `data[63:32] = 0x2233_xx11`.
- **Full with backpressure:** fill 4 distinct blocks with `wb_accept = 0`, then present a fifth block on lane 0.
  - Lanes 0 and 1: `sq_accept = 0`.
  - A store to a block held in a non-head entry is still accepted on lane 0.
- **Locked head:** head locked for block 0x200 with `wb_accept` low; present a new SB to 0x1001.
  - A new entry is allocated; the head's mask stays unchanged.
  - Drain order: old entry, then new entry.
- **Forwarding:** entries SW 0xAABBCCDD→0x2000 (older) and SB 0x55→0x2001 (younger); load 0x2000.
  - `ld_fwd_mask = 0xF`, `ld_fwd_data = 0xAABB55DD`.
- **Reset mid-drain:** reset while `wb_valid = 1`.
  - Next cycle: `wb_valid = 0`, `empty = 1`.
  - The next accepted store allocates slot 0.
